// File: rtl/hp_mem_pkg.sv
// hp_mem_pkg: shared FSM state types, AXI response codes and beat size for hp_mem_responder.
package hp_mem_pkg;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam int BEAT_BYTES = 16;
endpackage

// File: rtl/hp_mem_responder_if.sv
// hp_mem_responder_if: AXI4 HP bus (AW/W/B/AR/R) with master and slave views.
interface hp_mem_responder_if #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0]   hp_awaddr;
    logic [7:0]              hp_awlen;
    logic [2:0]              hp_awsize;
    logic [1:0]              hp_awburst;
    logic                    hp_awvalid;
    logic                    hp_awready;
    logic [DATA_WIDTH-1:0]   hp_wdata;
    logic [DATA_WIDTH/8-1:0] hp_wstrb;
    logic                    hp_wlast;
    logic                    hp_wvalid;
    logic                    hp_wready;
    logic [1:0]              hp_bresp;
    logic                    hp_bvalid;
    logic                    hp_bready;
    logic [ADDR_WIDTH-1:0]   hp_araddr;
    logic [7:0]              hp_arlen;
    logic [2:0]              hp_arsize;
    logic [1:0]              hp_arburst;
    logic                    hp_arvalid;
    logic                    hp_arready;
    logic [DATA_WIDTH-1:0]   hp_rdata;
    logic [1:0]              hp_rresp;
    logic                    hp_rlast;
    logic                    hp_rvalid;
    logic                    hp_rready;
    modport master (
        output hp_awaddr, hp_awlen, hp_awsize, hp_awburst, hp_awvalid,
        output hp_wdata, hp_wstrb, hp_wlast, hp_wvalid, hp_bready,
        output hp_araddr, hp_arlen, hp_arsize, hp_arburst, hp_arvalid, hp_rready,
        input  hp_awready, hp_wready, hp_bresp, hp_bvalid,
        input  hp_arready, hp_rdata, hp_rresp, hp_rlast, hp_rvalid
    );
    modport slave (
        input  hp_awaddr, hp_awlen, hp_awsize, hp_awburst, hp_awvalid,
        input  hp_wdata, hp_wstrb, hp_wlast, hp_wvalid, hp_bready,
        input  hp_araddr, hp_arlen, hp_arsize, hp_arburst, hp_arvalid, hp_rready,
        output hp_awready, hp_wready, hp_bresp, hp_bvalid,
        output hp_arready, hp_rdata, hp_rresp, hp_rlast, hp_rvalid
    );
endinterface

// File: rtl/hp_mem_ram.sv
// hp_mem_ram: simple dual-port RAM, byte-enabled write port, registered read-first read port.
module hp_mem_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH/8-1:0]      wr_strb_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic                         rd_en_i,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i)
            for (int b = 0; b < DATA_WIDTH/8; b++)
                if (wr_strb_i[b]) mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
    end

    // Only the output register is reset; contents survive reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/hp_mem_responder.sv
// hp_mem_responder: AXI4 slave RAM model for the HP port; independent INCR write/read bursts of 16 B beats.
// Define HP_MEM_ADDR_CHECK_EN to answer bursts leaving the RAM with SLVERR instead of wrapping.
module hp_mem_responder
    import hp_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 128,
    parameter int MEM_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input logic clk,
    input logic rst,
    hp_mem_responder_if.slave bus
);
    localparam int WORD_W = $clog2(MEM_DEPTH);
    localparam int SH = $clog2(BEAT_BYTES);
    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t word_of(input logic [ADDR_WIDTH-1:0] a);
        return word_t'((a - BASE_ADDR) >> SH);
    endfunction

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    word_t w_word_q, w_word_d, r_word_q, r_word_d;
    logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [7:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic w_err_q, w_err_d, r_err_q, r_err_d;
    logic aw_bad, ar_bad;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic unused_ok;

`ifdef HP_MEM_ADDR_CHECK_EN
    localparam int FW = ADDR_WIDTH - SH + 1;
    typedef logic [FW-1:0] full_t;
    // Unwrapped word indices; any bit at or above WORD_W means outside the RAM.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len);
        full_t first, last;
        first = full_t'((a - BASE_ADDR) >> SH);
        last = first + full_t'(len);
        return ((first >> WORD_W) != '0) || ((last >> WORD_W) != '0);
    endfunction
    assign aw_bad = out_of_range(bus.hp_awaddr, bus.hp_awlen);
    assign ar_bad = out_of_range(bus.hp_araddr, bus.hp_arlen);
`else
    assign aw_bad = 1'b0;
    assign ar_bad = 1'b0;
`endif

    assign unused_ok = ^{bus.hp_awsize, bus.hp_awburst, bus.hp_wlast, bus.hp_arsize, bus.hp_arburst};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_word_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_word_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_word_q  <= w_word_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_word_q  <= r_word_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
        end
    end

    // Write burst ends on the beat count, never on wlast.
    always_comb begin
        w_state_d = w_state_q;
        w_word_d  = w_word_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: if (bus.hp_awvalid) begin
                w_state_d = W_DATA;
                w_word_d  = word_of(bus.hp_awaddr);
                w_len_d   = bus.hp_awlen;
                w_cnt_d   = '0;
                w_err_d   = aw_bad;
            end
            W_DATA: if (bus.hp_wvalid) begin
                w_state_d = (w_cnt_q == w_len_q) ? W_RESP : W_DATA;
                w_word_d  = w_word_q + word_t'(1);
                w_cnt_d   = w_cnt_q + 8'd1;
            end
            W_RESP: if (bus.hp_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_word_d  = r_word_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        case (r_state_q)
            R_IDLE: if (bus.hp_arvalid) begin
                r_state_d = R_FETCH;
                r_word_d  = word_of(bus.hp_araddr);
                r_len_d   = bus.hp_arlen;
                r_cnt_d   = '0;
                r_err_d   = ar_bad;
            end
            R_FETCH: r_state_d = R_DATA;
            R_DATA: if (bus.hp_rready) begin
                r_state_d = bus.hp_rlast ? R_IDLE : R_FETCH;
                r_word_d  = r_word_q + word_t'(1);
                r_cnt_d   = r_cnt_q + 8'd1;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Ready outputs are forced low while reset is asserted.
    assign bus.hp_awready = !rst && w_state_q == W_IDLE;
    assign bus.hp_wready  = w_state_q == W_DATA;
    assign bus.hp_bvalid  = w_state_q == W_RESP;
    assign bus.hp_bresp   = (bus.hp_bvalid && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign bus.hp_arready = !rst && r_state_q == R_IDLE;
    assign bus.hp_rvalid  = r_state_q == R_DATA;
    assign bus.hp_rlast   = bus.hp_rvalid && r_cnt_q == r_len_q;
    assign bus.hp_rresp   = (bus.hp_rvalid && r_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign bus.hp_rdata   = r_err_q ? '0 : ram_rdata;

    hp_mem_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MEM_DEPTH)) u_ram (
        .clk(clk),
        .rst(rst),
        .wr_en_i(bus.hp_wvalid && bus.hp_wready && !w_err_q),
        .wr_addr_i(w_word_q),
        .wr_strb_i(bus.hp_wstrb),
        .wr_data_i(bus.hp_wdata),
        .rd_en_i(r_state_q == R_FETCH),
        .rd_addr_i(r_word_q),
        .rd_data_o(ram_rdata)
    );
endmodule

// File: tb/tb_hp_mem_responder.sv
// tb_hp_mem_responder: randomized bursts against a word-array memory model, scoreboard on B and R channels.
module tb_hp_mem_responder;
    import hp_mem_pkg::*;
    localparam int AW = 48;
    localparam int DW = 128;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [1:0]    r;
    } rbeat_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    hp_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
    hp_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(48'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] wd [256];
    logic [15:0]   ws [256];
    logic [1:0]    bq [$];
    rbeat_t        rq [$];
    rbeat_t        mon_e;
    logic [DW-1:0] rsum, esum, held;
    bit            held_v = 0;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic timeout(input string n);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", n);
    endtask

    // Monitor: handshakes are decided by values held from negedge to the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.hp_bvalid && bus.hp_bready) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_b: bvalid with no burst pending, bresp %0d", bus.hp_bresp);
                end else check("bresp", bus.hp_bresp, bq.pop_front());
            end
            if (bus.hp_rvalid && held_v) check("rdata_stable", bus.hp_rdata, held);
            held_v = bus.hp_rvalid && !bus.hp_rready;
            held = bus.hp_rdata;
            if (bus.hp_rvalid && bus.hp_rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_r: rvalid with no read pending, rdata %h", bus.hp_rdata);
                end else begin
                    mon_e = rq.pop_front();
                    check("rdata", bus.hp_rdata, mon_e.d);
                    check("rlast", bus.hp_rlast, mon_e.l);
                    check("rresp", bus.hp_rresp, mon_e.r);
                    rsum = rsum + bus.hp_rdata;
                end
            end
        end else held_v = 0;
    end

    function automatic bit flagged(input logic [AW-1:0] addr, input int len);
        bit bad = 0;
`ifdef HP_MEM_ADDR_CHECK_EN
        bad = ((addr >> 4) + AW'(len)) >= AW'(DEPTH);
`endif
        return bad;
    endfunction

    task automatic wr_burst(input logic [AW-1:0] addr, input int len, input int bhold);
        int w, t;
        bit bad;
        w = int'(addr[13:4]);
        bad = flagged(addr, len);
        bq.push_back(bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
        if (!bad)
            for (int i = 0; i <= len; i++)
                for (int b = 0; b < 16; b++)
                    if (ws[i][b]) model[(w + i) % DEPTH][8*b +: 8] = wd[i][8*b +: 8];
        bus.hp_awaddr = addr;
        bus.hp_awlen = 8'(len);
        bus.hp_awsize = 3'd4;
        bus.hp_awburst = 2'b01;
        bus.hp_awvalid = 1;
        t = 0;
        while (!bus.hp_awready && t < 50) begin @(posedge clk); #1; t++; end
        if (t == 50) timeout("awready");
        @(posedge clk); #1;
        bus.hp_awvalid = 0;
        check("aw_to_wready", bus.hp_wready, 1);
        for (int i = 0; i <= len; i++) begin
            bus.hp_wvalid = 0;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            bus.hp_wdata = wd[i];
            bus.hp_wstrb = ws[i];
            bus.hp_wlast = (i == len);
            bus.hp_wvalid = 1;
            t = 0;
            while (!bus.hp_wready && t < 50) begin @(posedge clk); #1; t++; end
            if (t == 50) timeout("wready");
            @(posedge clk); #1;
        end
        bus.hp_wvalid = 0;
        bus.hp_wlast = 0;
        check("w_to_bvalid", bus.hp_bvalid, 1);
        repeat (bhold) begin
            check("b_hold_bvalid", bus.hp_bvalid, 1);
            check("b_hold_awready", bus.hp_awready, 0);
            @(posedge clk); #1;
        end
        bus.hp_bready = 1;
        @(posedge clk); #1;
        bus.hp_bready = 0;
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input int len, input bit rand_rdy);
        int w, t;
        bit bad;
        rbeat_t e;
        w = int'(addr[13:4]);
        bad = flagged(addr, len);
        for (int i = 0; i <= len; i++) begin
            e.d = bad ? '0 : model[(w + i) % DEPTH];
            e.l = (i == len);
            e.r = bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            rq.push_back(e);
        end
        bus.hp_araddr = addr;
        bus.hp_arlen = 8'(len);
        bus.hp_arsize = 3'd4;
        bus.hp_arburst = 2'b01;
        bus.hp_arvalid = 1;
        t = 0;
        while (!bus.hp_arready && t < 50) begin @(posedge clk); #1; t++; end
        if (t == 50) timeout("arready");
        @(posedge clk); #1;
        bus.hp_arvalid = 0;
        check("ar_fetch_gap", bus.hp_rvalid, 0);
        @(posedge clk); #1;
        check("ar_to_rvalid", bus.hp_rvalid, 1);
        t = 0;
        while (rq.size() != 0 && t < 4000) begin
            bus.hp_rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            t++;
        end
        bus.hp_rready = 0;
        if (t == 4000) begin
            timeout("read_beats");
            rq.delete();
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        int n;
        {bus.hp_awaddr, bus.hp_awlen, bus.hp_awsize, bus.hp_awburst, bus.hp_awvalid} = '0;
        {bus.hp_wdata, bus.hp_wstrb, bus.hp_wlast, bus.hp_wvalid, bus.hp_bready} = '0;
        {bus.hp_araddr, bus.hp_arlen, bus.hp_arsize, bus.hp_arburst, bus.hp_arvalid, bus.hp_rready} = '0;
        rsum = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", bus.hp_awready, 0);
        check("rst_arready", bus.hp_arready, 0);
        check("rst_wready", bus.hp_wready, 0);
        check("rst_bvalid", bus.hp_bvalid, 0);
        check("rst_rvalid", bus.hp_rvalid, 0);
        check("rst_rlast", bus.hp_rlast, 0);
        check("rst_rdata", bus.hp_rdata, 0);
        check("rst_resp", {bus.hp_bresp, bus.hp_rresp}, 0);
        rst = 0;
        #1;
        check("idle_awready", bus.hp_awready, 1);
        check("idle_arready", bus.hp_arready, 1);
        @(posedge clk); #1;

        wd[0] = 128'h0123456789abcdeffedcba9876543210;
        ws[0] = 16'hffff;
        wr_burst(48'h100, 0, 0);
        rd_burst(48'h100, 0, 0);

        wd[0] = '1;
        wr_burst(48'h2000, 0, 0);
        wd[0] = '0;
        ws[0] = 16'h00f0;
        wr_burst(48'h2000, 0, 0);
        rd_burst(48'h2000, 0, 1);

        esum = '0;
        wd[0] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 256; i++) begin
            wd[i] = wd[0] + DW'(i);
            ws[i] = 16'hffff;
            esum = esum + wd[i];
        end
        wr_burst(48'h1000, 255, 5);
        rsum = '0;
        rd_burst(48'h1000, 255, 1);
        check("burst_checksum", rsum, esum);

        // Prefill both ends of the RAM, then a burst straddling the top.
        ws[0] = 16'hffff;
        ws[1] = 16'hffff;
        wd[0] = {$urandom, $urandom, $urandom, $urandom};
        wr_burst(48'h3ff0, 0, 0);
        wd[0] = {$urandom, $urandom, $urandom, $urandom};
        wr_burst(48'h0, 0, 0);
        wd[0] = {$urandom, $urandom, $urandom, $urandom};
        wd[1] = {$urandom, $urandom, $urandom, $urandom};
        wr_burst(48'h3ff0, 1, 2);
        rd_burst(48'h3ff0, 1, 0);
        rd_burst(48'h3ff0, 0, 0);
        rd_burst(48'h0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            a = (AW'($urandom_range(0, DEPTH - 1)) << 4) | AW'($urandom_range(0, 15));
            n = $urandom_range(0, 15);
            for (int i = 0; i <= n; i++) begin
                wd[i] = {$urandom, $urandom, $urandom, $urandom};
                ws[i] = 16'hffff;
            end
            wr_burst(a, n, $urandom_range(0, 3));
            rd_burst(a, n, 1);
        end

        // Reset during beat 3 of an 8-beat write at word 0.
        for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom, $urandom, $urandom};
        bus.hp_awaddr = 48'h0;
        bus.hp_awlen = 8'd7;
        bus.hp_awvalid = 1;
        @(posedge clk); #1;
        bus.hp_awvalid = 0;
        for (int i = 0; i < 3; i++) begin
            bus.hp_wdata = wd[i];
            bus.hp_wstrb = 16'hffff;
            bus.hp_wvalid = 1;
            model[i] = wd[i];
            @(posedge clk); #1;
        end
        bus.hp_wdata = wd[3];
        #2 rst = 1;
        #1;
        check("midrst_wready", bus.hp_wready, 0);
        check("midrst_awready", bus.hp_awready, 0);
        check("midrst_bvalid", bus.hp_bvalid, 0);
        check("midrst_rvalid", bus.hp_rvalid, 0);
        bus.hp_wvalid = 0;
        @(posedge clk); #1;
        rst = 0;
        #1;
        check("postrst_awready", bus.hp_awready, 1);
        @(posedge clk); #1;
        rd_burst(48'h0, 2, 1);

        repeat (3) @(posedge clk);
        #1;
        check("bq_drained", 32'(bq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
